leve_pipe_ctl: RTL and testbench

Parametrised pipeline controller for the LEVE in-order core. It replaces the fixed 4-stage, never-stalling valid chain with an N-slot tracker that has:
- issue handshake
- RAW-hazard interlock on integer registers
- global hold
- branch flush of younger slots
- writeback strobe and retire counter

It sits between fetch/decode (issue side) and the IRF/ALU/CSR datapath, which use its slot valids as stage enables.

---
 rtl/leve_pipe_pkg.sv | 36 +++
 rtl/leve_hazard_cmp.sv | 23 ++
 rtl/leve_pipe_ctl.sv | 128 ++++++++++++
 tb/tb_leve_pipe_ctl.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/leve_pipe_pkg.sv
// Shared types and parameter bounds for the LEVE pipeline controller.
// Latency: none (types, constants and constant functions only).
// Backpressure: not applicable.
package leve_pipe_pkg;

    // Bounds on the pipeline shape.
    localparam int NSTAGE_MIN = 3;
    localparam int NSTAGE_MAX = 8;
    localparam int BR_SLOT_MIN = 1;

    // Slot fields are sized for the widest supported configuration; narrower
    // instances use the low bits and keep the upper bits at zero.
    localparam int RIDX_MAX = 8;
    localparam int TAG_MAX = 64;

    // One tracked pipeline slot.
    typedef struct packed {
        logic                valid;
        logic                rd_we;
        logic [RIDX_MAX-1:0] rd;
        logic [TAG_MAX-1:0]  tag;
    } slot_t;

    // Elaboration-time legality check for the pipeline shape.
    function automatic bit pipe_params_ok(input int nstage, input int br_slot);
        return (nstage >= NSTAGE_MIN) && (nstage <= NSTAGE_MAX) &&
               (br_slot >= BR_SLOT_MIN) && (br_slot <= nstage - 1);
    endfunction

    // Elaboration-time legality check for the field widths.
    function automatic bit width_params_ok(input int ridx_w, input int tag_w, input int cnt_w);
        return (ridx_w >= 1) && (ridx_w <= RIDX_MAX) &&
               (tag_w >= 1) && (tag_w <= TAG_MAX) && (cnt_w >= 1);
    endfunction

endpackage

// File: rtl/leve_hazard_cmp.sv
// RAW compare of one in-flight slot against both sources of the offered instruction.
// Latency: purely combinational.
// Backpressure: none; the result feeds the issue-stall decision in the parent.
module leve_hazard_cmp
    import leve_pipe_pkg::*;
#(
    parameter int RIDX_W = 5
) (
    input  logic              slot_valid,
    input  logic              slot_rd_we,
    input  logic [RIDX_W-1:0] slot_rd,
    input  logic [RIDX_W-1:0] rs1,
    input  logic              rs1_use,
    input  logic [RIDX_W-1:0] rs2,
    input  logic              rs2_use,
    output logic              hit
);

    // x0 is hard-wired zero, so a pending write to it never blocks a reader.
    assign hit = slot_valid & slot_rd_we & (slot_rd != '0) &
                 ((rs1_use & (rs1 == slot_rd)) | (rs2_use & (rs2 == slot_rd)));

endmodule

// File: rtl/leve_pipe_ctl.sv
// N-slot in-order pipeline tracker: issue handshake, RAW interlock, hold, branch flush, writeback/retire.
// Latency: an instruction issued in cycle t writes back in cycle t+NSTAGE-1 when no HOLD intervenes.
// Backpressure: IN_READY drops on HOLD or a RAW hazard; FLUSH forces IN_READY high and discards the offer.
module leve_pipe_ctl
    import leve_pipe_pkg::*;
#(
    parameter int NSTAGE  = 4,
    parameter int RIDX_W  = 5,
    parameter int TAG_W   = 32,
    parameter int BR_SLOT = 2,
    parameter int CNT_W   = 64
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     IN_VALID,
    output logic                     IN_READY,
    input  logic [RIDX_W-1:0]        IN_RS1,
    input  logic                     IN_RS1_USE,
    input  logic [RIDX_W-1:0]        IN_RS2,
    input  logic                     IN_RS2_USE,
    input  logic [RIDX_W-1:0]        IN_RD,
    input  logic                     IN_RD_WE,
    input  logic [TAG_W-1:0]         IN_TAG,
    input  logic                     HOLD,
    input  logic                     FLUSH,
    output logic [NSTAGE-2:0]        SLOT_VALID,
    output logic [(NSTAGE-1)*TAG_W-1:0] SLOT_TAG,
    output logic                     HAZARD,
    output logic                     WB_VALID,
    output logic [RIDX_W-1:0]        WB_RD,
    output logic [TAG_W-1:0]         WB_TAG,
    output logic [CNT_W-1:0]         RETIRE_CNT
);

    localparam int LAST = NSTAGE - 1;

    if (!pipe_params_ok(NSTAGE, BR_SLOT) || !width_params_ok(RIDX_W, TAG_W, CNT_W)) begin : g_param_err
        $error("leve_pipe_ctl: illegal NSTAGE/BR_SLOT/width parameters");
    end

    slot_t            slot_q [1:LAST];
    slot_t            slot_d [1:LAST];
    logic [NSTAGE-2:1] haz_hit;
    logic [LAST:1]    slot_unused;
    logic             issue;
    logic [CNT_W-1:0] retire_q;

    // RAW compare against every slot except the last, whose write lands this cycle.
    for (genvar k = 1; k <= NSTAGE - 2; k++) begin : g_haz
        leve_hazard_cmp #(.RIDX_W(RIDX_W)) u_cmp (
            .slot_valid (slot_q[k].valid),
            .slot_rd_we (slot_q[k].rd_we),
            .slot_rd    (slot_q[k].rd[RIDX_W-1:0]),
            .rs1        (IN_RS1),
            .rs1_use    (IN_RS1_USE),
            .rs2        (IN_RS2),
            .rs2_use    (IN_RS2_USE),
            .hit        (haz_hit[k])
        );
    end

    // Per-slot outputs; the reduction sinks the zero-padded upper field bits.
    for (genvar k = 1; k <= LAST; k++) begin : g_out
        assign SLOT_VALID[k-1]                 = slot_q[k].valid;
        assign SLOT_TAG[(k-1)*TAG_W +: TAG_W]  = slot_q[k].tag[TAG_W-1:0];
        assign slot_unused[k]                  = ^slot_q[k];
    end

    assign HAZARD   = IN_VALID & (|haz_hit);
    assign IN_READY = !RST & ((!HOLD & !HAZARD) | FLUSH);
    assign issue    = IN_VALID & IN_READY;

    assign WB_VALID   = !RST & !HOLD & slot_q[LAST].valid;
    assign WB_RD      = slot_q[LAST].rd_we ? slot_q[LAST].rd[RIDX_W-1:0] : '0;
    assign WB_TAG     = slot_q[LAST].tag[TAG_W-1:0];
    assign RETIRE_CNT = retire_q;

    // Next slot state: shift on !HOLD, then kill everything younger than the branch on FLUSH.
    always_comb begin
        for (int k = 1; k <= LAST; k++) begin
            slot_d[k] = slot_q[k];
        end
        if (!HOLD) begin
            for (int k = LAST; k >= 2; k--) begin
                slot_d[k] = slot_q[k-1];
            end
            slot_d[1] = '0;
            if (issue && !FLUSH) begin
                slot_d[1].valid = 1'b1;
                slot_d[1].rd_we = IN_RD_WE;
                slot_d[1].rd    = RIDX_MAX'(IN_RD);
                slot_d[1].tag   = TAG_MAX'(IN_TAG);
            end
        end
        if (FLUSH) begin
            // Without HOLD the killed slots have already shifted up to BR_SLOT.
            for (int k = 1; k <= LAST; k++) begin
                if ((k < BR_SLOT) || ((k == BR_SLOT) && !HOLD)) begin
                    slot_d[k].valid = 1'b0;
                end
            end
        end
    end

    // Slot registers; reset only clears the valids, payload is don't-care.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int k = 1; k <= LAST; k++) begin
                slot_q[k].valid <= 1'b0;
            end
        end else begin
            slot_q <= slot_d;
        end
    end

    // Retired-instruction counter, wraps naturally at 2^CNT_W.
    always_ff @(posedge CLK) begin
        if (RST) begin
            retire_q <= '0;
        end else if (WB_VALID) begin
            retire_q <= retire_q + CNT_W'(1);
        end
    end

    // A redirect must come from a live branch in the resolving slot.
    a_flush_live: assert property (@(posedge CLK) disable iff (RST) FLUSH |-> slot_q[BR_SLOT].valid);

endmodule

// File: tb/tb_leve_pipe_ctl.sv
// Directed bench for leve_pipe_ctl with NSTAGE=4, BR_SLOT=2.
// Inputs change 1 time unit after each rising edge; outputs are sampled 1 unit later.
// Every expected value below is hand-derived from the cycle-by-cycle slot contents.
module tb_leve_pipe_ctl;

    localparam int NSTAGE  = 4;
    localparam int RIDX_W  = 5;
    localparam int TAG_W   = 32;
    localparam int BR_SLOT = 2;
    localparam int CNT_W   = 64;

    logic                        CLK = 1'b0;
    logic                        RST;
    logic                        IN_VALID;
    logic                        IN_READY;
    logic [RIDX_W-1:0]           IN_RS1;
    logic                        IN_RS1_USE;
    logic [RIDX_W-1:0]           IN_RS2;
    logic                        IN_RS2_USE;
    logic [RIDX_W-1:0]           IN_RD;
    logic                        IN_RD_WE;
    logic [TAG_W-1:0]            IN_TAG;
    logic                        HOLD;
    logic                        FLUSH;
    logic [NSTAGE-2:0]           SLOT_VALID;
    logic [(NSTAGE-1)*TAG_W-1:0] SLOT_TAG;
    logic                        HAZARD;
    logic                        WB_VALID;
    logic [RIDX_W-1:0]           WB_RD;
    logic [TAG_W-1:0]            WB_TAG;
    logic [CNT_W-1:0]            RETIRE_CNT;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 CLK = ~CLK;

    leve_pipe_ctl #(
        .NSTAGE(NSTAGE), .RIDX_W(RIDX_W), .TAG_W(TAG_W), .BR_SLOT(BR_SLOT), .CNT_W(CNT_W)
    ) dut (
        .CLK(CLK), .RST(RST),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .IN_RS1(IN_RS1), .IN_RS1_USE(IN_RS1_USE),
        .IN_RS2(IN_RS2), .IN_RS2_USE(IN_RS2_USE),
        .IN_RD(IN_RD), .IN_RD_WE(IN_RD_WE), .IN_TAG(IN_TAG),
        .HOLD(HOLD), .FLUSH(FLUSH),
        .SLOT_VALID(SLOT_VALID), .SLOT_TAG(SLOT_TAG), .HAZARD(HAZARD),
        .WB_VALID(WB_VALID), .WB_RD(WB_RD), .WB_TAG(WB_TAG),
        .RETIRE_CNT(RETIRE_CNT)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic offer(input int rd, input bit we, input int rs1, input bit u1,
                         input int rs2, input bit u2, input int tag);
        IN_VALID   = 1'b1;
        IN_RD      = RIDX_W'(rd);
        IN_RD_WE   = we;
        IN_RS1     = RIDX_W'(rs1);
        IN_RS1_USE = u1;
        IN_RS2     = RIDX_W'(rs2);
        IN_RS2_USE = u2;
        IN_TAG     = TAG_W'(tag);
    endtask

    task automatic idle();
        offer(0, 1'b0, 0, 1'b0, 0, 1'b0, 0);
        IN_VALID = 1'b0;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic look();
        #1;
    endtask

    function automatic logic [TAG_W-1:0] slot_tag(input int k);
        return SLOT_TAG[(k-1)*TAG_W +: TAG_W];
    endfunction

    initial begin
        RST = 1'b1; HOLD = 1'b0; FLUSH = 1'b0;
        offer(1, 1'b1, 0, 1'b0, 0, 1'b0, 'h50);

        // Reset: handshake and writeback gated while RST is high.
        tick();
        look();
        chk("rst_in_ready", IN_READY, 0);
        chk("rst_wb_valid", WB_VALID, 0);
        tick();
        RST = 1'b0;
        idle();
        look();
        chk("rst_slot_valid", SLOT_VALID, 0);
        chk("rst_retire_cnt", RETIRE_CNT, 0);

        // 1: eight independent writers; unused source fields must not stall.
        for (int i = 1; i <= 11; i++) begin
            if (i <= 8) offer(i, 1'b1, i - 1, 1'b0, i, 1'b0, 'h1000 + 4 * i);
            else        idle();
            look();
            if (i <= 8) chk("t1_in_ready", IN_READY, 1);
            chk("t1_wb_valid", WB_VALID, (i >= 4) ? 1 : 0);
            if (i >= 4) begin
                chk("t1_wb_rd", WB_RD, i - 3);
                chk("t1_wb_tag", WB_TAG, 'h1000 + 4 * (i - 3));
            end
            tick();
        end
        idle();
        look();
        chk("t1_retire_cnt", RETIRE_CNT, 8);
        chk("t1_slot_valid", SLOT_VALID, 0);

        // 2: writer x5 then consumer of x5 stalls while x5 sits in slots 1 and 2.
        offer(5, 1'b1, 0, 1'b0, 0, 1'b0, 'h2000);
        look();
        chk("t2_w_ready", IN_READY, 1);
        chk("t2_w_hazard", HAZARD, 0);
        tick();
        offer(6, 1'b1, 5, 1'b1, 0, 1'b0, 'h2004);
        look();
        chk("t2_c1_hazard", HAZARD, 1);
        chk("t2_c1_ready", IN_READY, 0);
        tick();
        look();
        chk("t2_c2_hazard", HAZARD, 1);
        chk("t2_c2_ready", IN_READY, 0);
        tick();
        look();
        chk("t2_c3_hazard", HAZARD, 0);
        chk("t2_c3_ready", IN_READY, 1);
        chk("t2_x5_wb_valid", WB_VALID, 1);
        chk("t2_x5_wb_rd", WB_RD, 5);
        tick();
        idle();
        look();
        chk("t2_gap_wb_valid", WB_VALID, 0);
        tick();
        tick();
        look();
        chk("t2_x6_wb_valid", WB_VALID, 1);
        chk("t2_x6_wb_rd", WB_RD, 6);
        chk("t2_x6_wb_tag", WB_TAG, 'h2004);
        tick();
        look();
        chk("t2_retire_cnt", RETIRE_CNT, 10);

        // 3: x0 and non-writing producers never interlock; WB_RD is 0 without rd_we.
        offer(0, 1'b1, 0, 1'b0, 0, 1'b0, 'h3000);
        tick();
        offer(7, 1'b1, 0, 1'b1, 0, 1'b1, 'h3004);
        look();
        chk("t3_x0_hazard", HAZARD, 0);
        chk("t3_x0_ready", IN_READY, 1);
        tick();
        offer(9, 1'b0, 0, 1'b0, 0, 1'b0, 'h3008);
        tick();
        offer(10, 1'b1, 9, 1'b1, 0, 1'b0, 'h300C);
        look();
        chk("t3_nowe_hazard", HAZARD, 0);
        chk("t3_x0w_wb_rd", WB_RD, 0);
        chk("t3_x0w_wb_tag", WB_TAG, 'h3000);
        tick();
        idle();
        look();
        chk("t3_c_wb_rd", WB_RD, 7);
        tick();
        look();
        chk("t3_nowe_wb_valid", WB_VALID, 1);
        chk("t3_nowe_wb_rd", WB_RD, 0);
        chk("t3_nowe_wb_tag", WB_TAG, 'h3008);
        tick();
        look();
        chk("t3_last_wb_rd", WB_RD, 10);
        tick();
        look();
        chk("t3_retire_cnt", RETIRE_CNT, 14);
        chk("t3_slot_valid", SLOT_VALID, 0);

        // 4: full pipe, FLUSH from slot 2 drops slot 1 and the offered instruction.
        offer(1, 1'b1, 0, 1'b0, 0, 1'b0, 'h100);
        tick();
        offer(2, 1'b1, 0, 1'b0, 0, 1'b0, 'h104);
        tick();
        offer(3, 1'b1, 0, 1'b0, 0, 1'b0, 'h108);
        tick();
        offer(4, 1'b1, 0, 1'b0, 3, 1'b1, 'h10C);
        look();
        chk("t4_rs2_hazard", HAZARD, 1);
        FLUSH = 1'b1;
        look();
        chk("t4_flush_ready", IN_READY, 1);
        chk("t4_full_valid", SLOT_VALID, 3'b111);
        chk("t4_slot1_tag", slot_tag(1), 'h108);
        chk("t4_wb_tag", WB_TAG, 'h100);
        tick();
        FLUSH = 1'b0;
        idle();
        look();
        chk("t4_post_valid", SLOT_VALID, 3'b100);
        chk("t4_br_wb_valid", WB_VALID, 1);
        chk("t4_br_wb_tag", WB_TAG, 'h104);
        tick();
        look();
        chk("t4_drained", SLOT_VALID, 0);
        chk("t4_no_wb", WB_VALID, 0);
        chk("t4_retire_cnt", RETIRE_CNT, 16);

        // 5: HOLD five cycles with a full pipe, then resume in order.
        offer(1, 1'b1, 0, 1'b0, 0, 1'b0, 'h200);
        tick();
        offer(2, 1'b1, 0, 1'b0, 0, 1'b0, 'h204);
        tick();
        offer(3, 1'b1, 0, 1'b0, 0, 1'b0, 'h208);
        tick();
        offer(4, 1'b1, 0, 1'b0, 0, 1'b0, 'h20C);
        HOLD = 1'b1;
        for (int c = 0; c < 5; c++) begin
            look();
            chk("t5_hold_valid", SLOT_VALID, 3'b111);
            chk("t5_hold_tag1", slot_tag(1), 'h208);
            chk("t5_hold_tag3", slot_tag(3), 'h200);
            chk("t5_hold_wb", WB_VALID, 0);
            chk("t5_hold_ready", IN_READY, 0);
            chk("t5_hold_cnt", RETIRE_CNT, 16);
            tick();
        end
        HOLD = 1'b0;
        look();
        chk("t5_rel_ready", IN_READY, 1);
        chk("t5_rel_wb_tag", WB_TAG, 'h200);
        chk("t5_rel_wb_valid", WB_VALID, 1);
        tick();
        idle();
        look();
        chk("t5_wb2_tag", WB_TAG, 'h204);
        tick();
        look();
        chk("t5_wb3_tag", WB_TAG, 'h208);
        tick();
        look();
        chk("t5_wb4_tag", WB_TAG, 'h20C);
        chk("t5_wb4_rd", WB_RD, 4);
        tick();
        look();
        chk("t5_retire_cnt", RETIRE_CNT, 20);

        // 6: reset mid-stream discards in-flight work without writeback.
        offer(1, 1'b1, 0, 1'b0, 0, 1'b0, 'h300);
        tick();
        offer(2, 1'b1, 0, 1'b0, 0, 1'b0, 'h304);
        tick();
        offer(3, 1'b1, 0, 1'b0, 0, 1'b0, 'h308);
        tick();
        offer(4, 1'b1, 0, 1'b0, 0, 1'b0, 'h30C);
        RST = 1'b1;
        look();
        chk("t6_pre_valid", SLOT_VALID, 3'b111);
        chk("t6_rst_ready", IN_READY, 0);
        chk("t6_rst_wb", WB_VALID, 0);
        tick();
        RST = 1'b0;
        offer(11, 1'b1, 0, 1'b0, 0, 1'b0, 'h400);
        look();
        chk("t6_post_valid", SLOT_VALID, 0);
        chk("t6_post_cnt", RETIRE_CNT, 0);
        chk("t6_post_wb", WB_VALID, 0);
        tick();
        idle();
        tick();
        tick();
        look();
        chk("t6_new_wb_valid", WB_VALID, 1);
        chk("t6_new_wb_rd", WB_RD, 11);
        chk("t6_new_wb_tag", WB_TAG, 'h400);
        tick();
        look();
        chk("t6_new_cnt", RETIRE_CNT, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
